// File: rtl/ula_div_pkg.sv
// Shared types and constants for the ULA sequential divider.
package ula_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Divide-by-zero quotient is all ones; replicate this bit to the operand width.
  localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/ula_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, select.
module ula_div_step
  import ula_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // On a borrow the shifted remainder is below D, so its low WIDTH bits hold it exactly.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial   = shifted - {1'b0, d};
    borrow  = trial[WIDTH];
    r_next  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next  = {q[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/ula_div_seq.sv
// Multi-cycle restoring divider for DIV/REM with valid/ready handshakes on both sides.
// Define ULA_DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module ula_div_seq
  import ula_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;
  logic             accept;
  logic             zero_div;

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign accept      = start_valid && start_ready;
  assign zero_div    = (divisor == '0);

`ifdef ULA_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // The core works on magnitudes; signs are restored in FIX. Most-negative / -1
  // falls out naturally as the unsigned magnitude 2^(WIDTH-1) with no negation.
  always_comb begin
    dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    q_fixed      = neg_q ? -q_q : q_q;
    r_fixed      = neg_r ? -r_q : r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= is_signed && dividend[WIDTH-1];
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;

  always_comb begin
    dividend_abs = dividend;
    divisor_abs  = divisor;
    q_fixed      = q_q;
    r_fixed      = r_q;
  end
`endif

  ula_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = zero_div ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt == CNT_LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: if (res_ready) state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered results; a zero divisor skips straight to DONE from accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            q_q         <= dividend_abs;
            d_q         <= divisor_abs;
            r_q         <= '0;
            cnt         <= '0;
            div_by_zero <= zero_div;
            if (zero_div) begin
              quotient  <= {WIDTH{DIV0_Q_BIT}};
              remainder <= dividend;
              res_valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_q <= r_step;
          q_q <= q_step;
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        ST_FIX: begin
          quotient  <= q_fixed;
          remainder <= r_fixed;
          res_valid <= 1'b1;
        end
        ST_DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
